mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of one single-port memory; one transaction in flight.
// Define ARB_STARVE_GUARD_EN to let a waiting fetch win after STARVE_MAX consecutive data grants.
module mem_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_abort,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_wstrb,
    output logic                dm_rvalid,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_ready,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                stall_if,
    output logic                stall_mem
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]          state;
    logic                owner_dm;
    logic                drop;
    logic [ADDR_W-3:0]   addr_q;
    logic                we_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wstrb_q;
    logic [DATA_W-1:0]   resp_q;
    logic [DATA_W-1:0]   if_last_q;
    logic [DATA_W-1:0]   dm_last_q;
    logic                grant_dm;

`ifdef ARB_STARVE_GUARD_EN
    logic [2:0] starve_cnt;

    assign grant_dm = dm_req && !(if_req && (starve_cnt >= 3'(STARVE_MAX)));

    always_ff @(posedge clk) begin
        if (rst || !if_req) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            // if_req is high here, so every IDLE cycle ends in a grant
            starve_cnt <= grant_dm ? starve_cnt + 3'd1 : 3'd0;
        end
    end
`else
    assign grant_dm = dm_req;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner_dm  <= 1'b0;
            drop      <= 1'b0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            resp_q    <= '0;
            if_last_q <= '0;
            dm_last_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (if_req || dm_req) begin
                        owner_dm <= grant_dm;
                        drop     <= 1'b0;
                        state    <= ISSUE;
                        if (grant_dm) begin
                            addr_q  <= dm_addr[ADDR_W-1:2];
                            we_q    <= dm_we;
                            wdata_q <= dm_wdata;
                            wstrb_q <= dm_wstrb;
                        end else begin
                            addr_q  <= if_addr[ADDR_W-1:2];
                            we_q    <= 1'b0;
                            wdata_q <= '0;
                            wstrb_q <= '0;
                        end
                    end
                end
                ISSUE: if (mem_ready) state <= WAIT;
                WAIT: begin
                    if (mem_rvalid) begin
                        resp_q <= mem_rdata;
                        state  <= RESP;
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
            if (state != IDLE && !owner_dm && if_abort) drop <= 1'b1;
            if (if_rvalid) if_last_q <= resp_q;
            if (dm_rvalid) dm_last_q <= resp_q;
        end
    end

    // An abort arriving in the RESP cycle itself still suppresses the pulse
    assign if_rvalid = (state == RESP) && !owner_dm && !drop && !if_abort;
    assign dm_rvalid = (state == RESP) && owner_dm;
    assign if_rdata  = if_rvalid ? resp_q : if_last_q;
    assign dm_rdata  = dm_rvalid ? resp_q : dm_last_q;

    assign mem_req   = (state == ISSUE);
    assign mem_we    = we_q;
    assign mem_addr  = {addr_q, 2'b00};
    assign mem_wdata = wdata_q;
    assign mem_wstrb = wstrb_q;

    assign stall_if  = if_req & ~if_rvalid;
    assign stall_mem = dm_req & ~dm_rvalid;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model of arbitration, latency, abort and starvation rules.
`timescale 1ns/1ps
module tb_mem_arbiter;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif
    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_abort, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        dm_req, dm_we, dm_rvalid;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  dm_wstrb;
    logic        mem_req, mem_we, mem_ready, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        stall_if, stall_mem;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: consecutive data grants while fetch waits, last delivered data per port
    int          cnt = 0;
    logic [31:0] exp_if_last = '0;
    logic [31:0] exp_dm_last = '0;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_abort(if_abort),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_wstrb(dm_wstrb), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc_check(input string ph, input logic e_req, input logic e_ifv,
                             input logic e_dmv);
        #1;
        check({ph, " mem_req"}, mem_req, e_req);
        check({ph, " if_rvalid"}, if_rvalid, e_ifv);
        check({ph, " dm_rvalid"}, dm_rvalid, e_dmv);
        check({ph, " if_rdata"}, if_rdata, exp_if_last);
        check({ph, " dm_rdata"}, dm_rdata, exp_dm_last);
        check({ph, " stall_if"}, stall_if, if_req & ~e_ifv);
        check({ph, " stall_mem"}, stall_mem, dm_req & ~e_dmv);
    endtask

    // Entered at the negedge of the IDLE cycle with requests already driven; returns at the
    // negedge after the response cycle. obs_dm reports which port the DUT actually issued.
    task automatic run_txn(input int rdly, input int vdly, input bit abort_it,
                           input logic [31:0] rd, output bit win_dm, output bit obs_dm);
        logic [31:0] e_addr;
        logic        e_we;
        logic [3:0]  e_strb;
        bit          ifv, dmv;
        win_dm = dm_req && !(GUARD && if_req && cnt >= STARVE_MAX);
        e_addr = win_dm ? dm_addr : if_addr;
        e_addr = e_addr & 32'hFFFF_FFFC;
        e_we   = win_dm ? dm_we : 1'b0;
        e_strb = win_dm ? dm_wstrb : 4'h0;
        if (!if_req) cnt = 0;
        else if (win_dm) cnt++;
        else cnt = 0;
        obs_dm = 1'b0;
        cyc_check("idle", 1'b0, 1'b0, 1'b0);
        for (int k = 0; k <= rdly; k++) begin
            @(negedge clk);
            mem_ready  = (k == rdly);
            mem_rvalid = (k != rdly) ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_rdata  = $urandom;
            cyc_check("issue", 1'b1, 1'b0, 1'b0);
            check("mem_addr", mem_addr, e_addr);
            check("mem_we", mem_we, e_we);
            check("mem_wstrb", mem_wstrb, e_strb);
            if (win_dm && e_we) check("mem_wdata", mem_wdata, dm_wdata);
            if (k == 0) obs_dm = mem_addr[31];
        end
        for (int k = 0; k <= vdly; k++) begin
            @(negedge clk);
            mem_ready  = 1'($urandom_range(0, 1));
            mem_rvalid = (k == vdly);
            mem_rdata  = (k == vdly) ? rd : $urandom;
            if_abort   = abort_it && (k == 0);
            cyc_check("wait", 1'b0, 1'b0, 1'b0);
        end
        @(negedge clk);
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        if_abort   = 1'b0;
        ifv = !win_dm && !abort_it;
        dmv = win_dm;
        if (ifv) exp_if_last = rd;
        if (dmv) exp_dm_last = rd;
        cyc_check("resp", 1'b0, ifv, dmv);
        @(negedge clk);
    endtask

    task automatic set_if(input bit req, input logic [31:0] a);
        if_req  = req;
        if_addr = a;
    endtask

    task automatic set_dm(input bit req, input bit we, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s);
        dm_req   = req;
        dm_we    = we;
        dm_addr  = a;
        dm_wdata = d;
        dm_wstrb = s;
    endtask

    initial begin
        bit          w, o;
        bit          need_if, need_dm;
        int          fetch_grants;
        logic [31:0] tmp;

        rst = 1'b1;
        if_abort = 1'b0;
        mem_ready = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = '0;
        set_if(1'b0, '0);
        set_dm(1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        cyc_check("reset", 1'b0, 1'b0, 1'b0);
        check("reset mem_addr", mem_addr, 0);
        check("reset mem_we", mem_we, 0);
        check("reset mem_wdata", mem_wdata, 0);
        check("reset mem_wstrb", mem_wstrb, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single fetch at minimum latency
        set_if(1'b1, 32'h104);
        run_txn(0, 0, 1'b0, 32'h0000_0013, w, o);
        check("single fetch owner", o, 1'b0);
        set_if(1'b0, '0);
        cyc_check("after fetch", 1'b0, 1'b0, 1'b0);
        @(negedge clk);

        // Simultaneous requests: data write first, then fetch
        set_if(1'b1, 32'h200);
        set_dm(1'b1, 1'b1, 32'h1000, 32'hDEAD_BEEF, 4'hF);
        run_txn(0, 0, 1'b0, $urandom, w, o);
        check("simul first owner", o, 1'b0 | (dm_addr[31] == 1'b0 ? 1'b0 : 1'b1));
        set_dm(1'b0, 1'b0, '0, '0, '0);
        run_txn(1, 0, 1'b0, $urandom, w, o);
        set_if(1'b0, '0);

        // Aborted fetch, then a normal one
        set_if(1'b1, 32'h300);
        run_txn(1, 1, 1'b1, 32'hAAAA_5555, w, o);
        set_if(1'b1, 32'h304);
        run_txn(0, 2, 1'b0, 32'h1234_5678, w, o);
        set_if(1'b0, '0);

        // mem_ready held off for five cycles with both ports pending
        set_if(1'b1, 32'h400);
        set_dm(1'b1, 1'b0, 32'h8000_0040, '0, 4'h0);
        run_txn(5, 1, 1'b0, $urandom, w, o);
        if (w) set_dm(1'b0, 1'b0, '0, '0, '0);
        else set_if(1'b0, '0);
        run_txn(0, 0, 1'b0, $urandom, w, o);
        set_if(1'b0, '0);
        set_dm(1'b0, 1'b0, '0, '0, '0);
        cyc_check("gap", 1'b0, 1'b0, 1'b0);
        cnt = 0;
        @(negedge clk);

        // Reset while waiting for memory; late mem_rvalid must be ignored
        set_if(1'b1, 32'h500);
        cyc_check("rst idle", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        mem_ready = 1'b1;
        cyc_check("rst issue", 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        mem_ready = 1'b0;
        set_if(1'b0, '0);
        rst = 1'b1;
        cyc_check("rst wait", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
        exp_if_last = '0;
        exp_dm_last = '0;
        cnt = 0;
        cyc_check("rst late rvalid", 1'b0, 1'b0, 1'b0);
        check("rst mem_addr", mem_addr, 0);
        @(negedge clk);
        mem_rvalid = 1'b0;
        cyc_check("rst after", 1'b0, 1'b0, 1'b0);
        @(negedge clk);

        // Both ports saturating a zero-wait memory
        fetch_grants = 0;
        set_if(1'b1, 32'h0000_0600);
        set_dm(1'b1, 1'b0, 32'h8000_0100, '0, 4'h0);
        for (int t = 0; t < 10; t++) begin
            run_txn(0, 0, 1'b0, $urandom, w, o);
            if (!o) fetch_grants++;
        end
        check("starve fetch grants", fetch_grants, GUARD ? 2 : 0);
        set_if(1'b0, '0);
        set_dm(1'b0, 1'b0, '0, '0, '0);
        cyc_check("starve gap", 1'b0, 1'b0, 1'b0);
        cnt = 0;
        @(negedge clk);

        // Randomized traffic; a port re-rolls its request only after being served
        need_if = 1'b1;
        need_dm = 1'b1;
        for (int t = 0; t < 80; t++) begin
            if (need_if) begin
                tmp = $urandom;
                set_if($urandom_range(0, 3) != 0, tmp & 32'h7FFF_FFFF);
            end
            if (need_dm) begin
                tmp = $urandom;
                set_dm($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                       tmp | 32'h8000_0000, $urandom, 4'($urandom_range(0, 15)));
            end
            if (!if_req && !dm_req) begin
                cyc_check("rand idle", 1'b0, 1'b0, 1'b0);
                cnt = 0;
                @(negedge clk);
                need_if = 1'b1;
                need_dm = 1'b1;
            end else begin
                run_txn($urandom_range(0, 3), $urandom_range(0, 3),
                        $urandom_range(0, 4) == 0, $urandom, w, o);
                check("rand owner", o, w);
                need_if = !w || !if_req;
                need_dm = w || !dm_req;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
